// File: rtl/parity_rr_scheduler.sv
// Round-robin arbiter feeding one shared serial even-parity engine; reports parity and winner index.
// Optional macro PARITY_ODD_CNT_EN adds o_odd_cnt, a saturating count of odd-parity results.
//
//   state | meaning
//   IDLE  | waiting for any request; arbitrates and captures the winner's word
//   SHIFT | streams the captured word LSB-first through the parity accumulator
//   DONE  | one-cycle result strobe; grant drops on exit
module parity_rr_scheduler #(
    parameter int  N    = 4,
    parameter int  W    = 8,
    localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N-1:0]      i_req,
    input  logic [N*W-1:0]    i_data,
    output logic [N-1:0]      o_gnt,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_even,
    output logic [ID_W-1:0]   o_id
`ifdef PARITY_ODD_CNT_EN
    ,
    output logic [7:0]        o_odd_cnt
`endif
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   win_q, win_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [W-1:0]      shreg_q, shreg_d;
    logic              par_q, par_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              even_q, even_d;
    logic [ID_W-1:0]   id_q, id_d;

    logic [N-1:0]      lo_mask;
    logic [N-1:0]      req_hi;
    logic [N-1:0]      req_pick;
    logic [ID_W-1:0]   arb_idx;
    logic [N-1:0]      arb_onehot;
    logic [W-1:0]      arb_word;
    logic              last_bit;
    logic              fin_par;

    // Requests at or above the pointer take priority; otherwise wrap to the lowest index.
    always_comb begin
        lo_mask    = (N'(1) << ptr_q) - N'(1);
        req_hi     = i_req & ~lo_mask;
        req_pick   = (|req_hi) ? req_hi : i_req;
        arb_idx    = '0;
        arb_onehot = '0;
        arb_word   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_pick[j]) begin
                arb_idx = ID_W'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (arb_idx == ID_W'(j)) begin
                arb_onehot[j] = 1'b1;
                arb_word      = i_data[j*W +: W];
            end
        end
    end

    assign last_bit = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
    // Mealy view of the accumulator: includes the bit being shifted this cycle.
    assign fin_par  = par_q ^ shreg_q[0];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        even_d  = even_q;
        id_d    = id_q;
        case (state_q)
            S_IDLE: begin
                if (|i_req) begin
                    gnt_d   = arb_onehot;
                    win_d   = arb_idx;
                    shreg_d = arb_word;
                    par_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                par_d   = fin_par;
                shreg_d = shreg_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    even_d  = ~fin_par;
                    id_d    = win_q;
                    ptr_d   = (win_q == ID_W'(N - 1)) ? '0 : win_q + ID_W'(1);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            cnt_q   <= '0;
            even_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            cnt_q   <= cnt_d;
            even_q  <= even_d;
            id_q    <= id_d;
        end
    end

    assign o_gnt  = gnt_q;
    assign o_busy = (state_q != S_IDLE);
    assign o_done = (state_q == S_DONE);
    assign o_even = even_q;
    assign o_id   = id_q;

`ifdef PARITY_ODD_CNT_EN
    logic [7:0] odd_cnt_q, odd_cnt_d;

    always_comb begin
        odd_cnt_d = odd_cnt_q;
        if (last_bit && fin_par && (odd_cnt_q != 8'hFF)) begin
            odd_cnt_d = odd_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            odd_cnt_q <= 8'd0;
        end else begin
            odd_cnt_q <= odd_cnt_d;
        end
    end

    assign o_odd_cnt = odd_cnt_q;
`endif

endmodule

// File: tb/tb_parity_rr_scheduler.sv
// Directed and randomized frames for parity_rr_scheduler, checked against a round-robin/popcount model.
module tb_parity_rr_scheduler;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int ID_W = 2;

    logic              clk;
    logic              i_rst;
    logic [N-1:0]      i_req;
    logic [N*W-1:0]    i_data;
    logic [N-1:0]      o_gnt;
    logic              o_busy;
    logic              o_done;
    logic              o_even;
    logic [ID_W-1:0]   o_id;
`ifdef PARITY_ODD_CNT_EN
    logic [7:0]        o_odd_cnt;
`endif

    parity_rr_scheduler #(.N(N), .W(W)) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_req    (i_req),
        .i_data   (i_data),
        .o_gnt    (o_gnt),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_even   (o_even),
        .o_id     (o_id)
`ifdef PARITY_ODD_CNT_EN
        ,
        .o_odd_cnt(o_odd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    int m_ptr     = 0;
    int m_odd     = 0;
    int m_id      = 0;
    int m_even    = 0;
    int last_done = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst = 1'b1;
        i_req = '0;
        @(posedge clk);
        #1;
        i_rst     = 1'b0;
        m_ptr     = 0;
        m_odd     = 0;
        m_id      = 0;
        m_even    = 0;
        last_done = -1;
    endtask

    // mode 0: inputs held; 1: inputs randomized every SHIFT cycle; 2: req dropped and data inverted mid-frame
    task automatic do_frame(input logic [N-1:0] req, input logic [N*W-1:0] data,
                            input int mode, input bit b2b);
        int win;
        logic [W-1:0] word;
        logic [N-1:0] gexp;
        win = -1;
        for (int k = 0; k < N; k++) begin
            if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        end
        word = data[win*W +: W];
        gexp = N'(1) << win;
        @(negedge clk);
        i_req  = req;
        i_data = data;
        @(posedge clk);
        #1;
        chk("gnt_after_arb", o_gnt, gexp);
        chk("busy_after_arb", o_busy, 1);
        for (int c = 1; c <= W; c++) begin
            @(negedge clk);
            if (mode == 1) begin
                i_req  = N'($urandom);
                i_data = {$urandom, $urandom} >> (64 - N*W);
            end else if (mode == 2 && c == 2) begin
                i_req  = '0;
                i_data = ~data;
            end
            @(posedge clk);
            #1;
            chk("gnt_hold", o_gnt, gexp);
            chk("busy_hold", o_busy, 1);
            if (c < W) chk("done_early", o_done, 0);
        end
        m_id   = win;
        m_even = ($countones(word) % 2 == 0) ? 1 : 0;
        if (m_even == 0) m_odd = (m_odd < 255) ? m_odd + 1 : 255;
        m_ptr  = (win + 1) % N;
        chk("done_pulse", o_done, 1);
        chk("even_at_done", o_even, m_even);
        chk("id_at_done", o_id, m_id);
        if (b2b && last_done >= 0) chk("done_spacing", cyc - last_done, W + 2);
        last_done = cyc;
        i_req = '0;
        @(posedge clk);
        #1;
        chk("done_cleared", o_done, 0);
        chk("gnt_cleared", o_gnt, 0);
        chk("busy_cleared", o_busy, 0);
        chk("even_held", o_even, m_even);
        chk("id_held", o_id, m_id);
`ifdef PARITY_ODD_CNT_EN
        chk("odd_cnt", o_odd_cnt, m_odd);
`endif
    endtask

    initial begin
        i_rst  = 1'b1;
        i_req  = '0;
        i_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", o_gnt, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_even", o_even, 0);
        chk("rst_id", o_id, 0);
        @(negedge clk);
        i_rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("idle_gnt", o_gnt, 0);
            chk("idle_busy", o_busy, 0);
            chk("idle_done", o_done, 0);
        end

        // all requesting: rotation 0,1,2,3,0 with fixed 10-cycle spacing
        last_done = -1;
        for (int i = 0; i < 5; i++) begin
            do_frame(4'b1111, {8'hFF, 8'h07, 8'h03, 8'h01}, 0, 1'b1);
        end

        do_frame(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 0, 1'b0);

        do_frame(4'b1000, {8'h3C, 8'h00, 8'h00, 8'h00}, 0, 1'b0);
        do_frame(4'b1001, {8'h01, 8'h00, 8'h00, 8'h11}, 0, 1'b1);
        do_frame(4'b1001, {8'h01, 8'h00, 8'h00, 8'h11}, 0, 1'b1);

        do_reset();
        do_frame(4'b0010, {8'h00, 8'h00, 8'h80, 8'h00}, 2, 1'b0);

        // abort in SHIFT cycle 4 with a request present during the reset edge
        do_frame(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 0, 1'b0);
        @(negedge clk);
        i_req  = 4'b0100;
        i_data = {8'h00, 8'h0F, 8'h00, 8'h00};
        @(posedge clk);
        for (int c = 1; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk("pre_abort_done", o_done, 0);
        end
        @(negedge clk);
        i_rst = 1'b1;
        i_req = 4'b1010;
        @(posedge clk);
        #1;
        chk("abort_gnt", o_gnt, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_done", o_done, 0);
        chk("abort_even", o_even, 0);
        chk("abort_id", o_id, 0);
`ifdef PARITY_ODD_CNT_EN
        chk("abort_odd_cnt", o_odd_cnt, 0);
`endif
        i_rst     = 1'b0;
        m_ptr     = 0;
        m_odd     = 0;
        last_done = -1;
        do_frame(4'b1010, {8'h00, 8'h33, 8'h00, 8'h07}, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_frame(N'($urandom_range(1, (1 << N) - 1)), N*W'($urandom), 1, 1'b1);
        end

`ifdef PARITY_ODD_CNT_EN
        do_reset();
        for (int i = 0; i < 300; i++) begin
            do_frame(4'b0001, {8'h00, 8'h00, 8'h00, 8'h01}, 0, 1'b1);
        end
        chk("odd_cnt_saturated", o_odd_cnt, 255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
